// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insertion, PIN check with retry limit and
// lockout, withdrawal validation against a held balance, dispense handshake
// and an inactivity timeout. All outputs come straight from registers.
//
// Handshake: pin_valid / amt_valid are one-cycle strobes that are consumed
// only in the state that samples them (dropped elsewhere, never queued);
// dispense_req stays high for the whole DISPENSE state and the dispenser
// answers with a one-cycle dispense_ack, which completes the withdrawal.
module atm_session_ctrl #(
  parameter int               PIN_W        = 16,
  parameter logic [PIN_W-1:0] PIN_VALUE    = 16'h1234,
  parameter int               AMT_W        = 16,
  parameter int               BAL_W        = 24,
  parameter int               INIT_BALANCE = 500,
  parameter int               MAX_TRIES    = 3,
  parameter int               TIMEOUT_CYC  = 1000,
  parameter int               LOCK_CYC     = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic             cancel,
  input  logic             dispense_ack,
  output logic [2:0]       state,
  output logic             pin_ok,
  output logic             pin_err,
  output logic             amt_err,
  output logic             timeout,
  output logic             done,
  output logic             locked,
  output logic             dispense_req,
  output logic [AMT_W-1:0] dispense_amt,
  output logic [BAL_W-1:0] balance,
  output logic [3:0]       tries_left
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_AMOUNT = 3'd2,
    S_DISP   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  // One counter serves both the inactivity timer and the lockout duration;
  // the two are never live at the same time.
  localparam int CNT_MAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
  localparam int TW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [TW-1:0]    TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]    LK_LAST    = TW'(LOCK_CYC - 1);
  localparam logic [3:0]       TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [BAL_W-1:0] BAL_INIT   = BAL_W'(INIT_BALANCE);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       tries_q, tries_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             pin_ok_q, pin_ok_d;
  logic             pin_err_q, pin_err_d;
  logic             amt_err_q, amt_err_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             locked_q, req_q;

  // Next-state, counter and pulse decisions for the session FSM.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tries_d   = tries_q;
    bal_d     = bal_q;
    amt_d     = amt_q;
    pin_ok_d  = 1'b0;
    pin_err_d = 1'b0;
    amt_err_d = 1'b0;
    timeout_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (card_in) begin
          state_d = S_PIN;
          tries_d = TRIES_INIT;
          timer_d = '0;
        end
      end
      S_PIN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (pin_valid) begin
          timer_d = '0;
          if (pin == PIN_VALUE) begin
            state_d  = S_AMOUNT;
            pin_ok_d = 1'b1;
          end else begin
            pin_err_d = 1'b1;
            tries_d   = tries_q - 4'd1;
            // Last attempt used up: the counter restarts as the lock timer.
            if (tries_q == 4'd1) state_d = S_LOCKED;
          end
        end else if (timer_q == TO_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_AMOUNT: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (amt_valid) begin
          timer_d = '0;
          // Approval is the only place underflow is prevented.
          if (amount == '0 || BAL_W'(amount) > bal_q) begin
            amt_err_d = 1'b1;
          end else begin
            amt_d   = amount;
            state_d = S_DISP;
          end
        end else if (timer_q == TO_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DISP: begin
        if (dispense_ack) begin
          bal_d   = bal_q - BAL_W'(amt_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (timer_q == LK_LAST) begin
          state_d = S_IDLE;
          tries_d = TRIES_INIT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; status levels follow the next state
  // so they line up with the state output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      tries_q   <= TRIES_INIT;
      bal_q     <= BAL_INIT;
      amt_q     <= '0;
      pin_ok_q  <= 1'b0;
      pin_err_q <= 1'b0;
      amt_err_q <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      locked_q  <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tries_q   <= tries_d;
      bal_q     <= bal_d;
      amt_q     <= amt_d;
      pin_ok_q  <= pin_ok_d;
      pin_err_q <= pin_err_d;
      amt_err_q <= amt_err_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      locked_q  <= (state_d == S_LOCKED);
      req_q     <= (state_d == S_DISP);
    end
  end

  assign state        = state_q;
  assign pin_ok       = pin_ok_q;
  assign pin_err      = pin_err_q;
  assign amt_err      = amt_err_q;
  assign timeout      = timeout_q;
  assign done         = done_q;
  assign locked       = locked_q;
  assign dispense_req = req_q;
  assign dispense_amt = amt_q;
  assign balance      = bal_q;
  assign tries_left   = tries_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios followed by random traffic,
// checked against a session-level reference model through an event queue.
module tb_atm_session_ctrl;

  localparam int PV  = 16'h1234;
  localparam int IB  = 500;
  localparam int MT  = 3;
  localparam int TO  = 16;
  localparam int LK  = 8;
  localparam int EW  = 65;  // {cycle[15:0], pulses[4:0], balance[23:0], tries[3:0], amt[15:0]}

  logic        clk, reset;
  logic        card_in, pin_valid, amt_valid, cancel, dispense_ack;
  logic [15:0] pin, amount;
  logic [2:0]  state;
  logic        pin_ok, pin_err, amt_err, timeout, done, locked, dispense_req;
  logic [15:0] dispense_amt;
  logic [23:0] balance;
  logic [3:0]  tries_left;

  atm_session_ctrl #(
    .PIN_W(16), .PIN_VALUE(16'h1234), .AMT_W(16), .BAL_W(24),
    .INIT_BALANCE(IB), .MAX_TRIES(MT), .TIMEOUT_CYC(TO), .LOCK_CYC(LK)
  ) dut (
    .clk(clk), .reset(reset), .card_in(card_in), .pin_valid(pin_valid),
    .pin(pin), .amt_valid(amt_valid), .amount(amount), .cancel(cancel),
    .dispense_ack(dispense_ack), .state(state), .pin_ok(pin_ok),
    .pin_err(pin_err), .amt_err(amt_err), .timeout(timeout), .done(done),
    .locked(locked), .dispense_req(dispense_req), .dispense_amt(dispense_amt),
    .balance(balance), .tries_left(tries_left)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] pack_evt(int c, logic [4:0] k, int b, int t, int a);
    return {16'(c), k, 24'(b), 4'(t), 16'(a)};
  endfunction

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Session-level view: mode number, quiet cycles seen, lock cycles served,
  // attempts left, money held, last approved amount.
  int m_mode, m_idle, m_lock, m_tries, m_bal, m_amt;

  always @(posedge clk) begin
    logic [4:0] ev;  // {pin_ok, pin_err, amt_err, timeout, done}
    ev = '0;
    cyc++;
    if (reset) begin
      m_mode = 0; m_idle = 0; m_lock = 0; m_tries = MT; m_bal = IB; m_amt = 0;
    end else begin
      case (m_mode)
        0: if (card_in) begin m_mode = 1; m_tries = MT; m_idle = 0; end
        1: begin
          if (cancel) m_mode = 0;
          else if (pin_valid) begin
            m_idle = 0;
            if (int'(pin) == PV) begin m_mode = 2; ev[4] = 1'b1; end
            else begin
              ev[3] = 1'b1;
              m_tries = m_tries - 1;
              if (m_tries == 0) begin m_mode = 4; m_lock = 0; end
            end
          end else begin
            m_idle++;
            if (m_idle == TO) begin m_mode = 0; ev[1] = 1'b1; end
          end
        end
        2: begin
          if (cancel) m_mode = 0;
          else if (amt_valid) begin
            m_idle = 0;
            if (amount == 0 || int'(amount) > m_bal) ev[2] = 1'b1;
            else begin m_amt = int'(amount); m_mode = 3; end
          end else begin
            m_idle++;
            if (m_idle == TO) begin m_mode = 0; ev[1] = 1'b1; end
          end
        end
        3: if (dispense_ack) begin m_bal = m_bal - m_amt; m_mode = 0; ev[0] = 1'b1; end
        4: begin
          m_lock++;
          if (m_lock == LK) begin m_mode = 0; m_tries = MT; end
        end
        default: m_mode = 0;
      endcase
    end
    if (ev != '0) exp_q.push_back(pack_evt(cyc, ev, m_bal, m_tries, m_amt));
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [4:0] pulses;
    if (cyc > 0) begin
      pulses = {pin_ok, pin_err, amt_err, timeout, done};
      chk("state", 72'(state), 72'(m_mode));
      chk("locked", 72'(locked), 72'(m_mode == 4));
      chk("dispense_req", 72'(dispense_req), 72'(m_mode == 3));
      chk("balance", 72'(balance), 72'(m_bal));
      chk("tries_left", 72'(tries_left), 72'(m_tries));
      chk("dispense_amt", 72'(dispense_amt), 72'(m_amt));
      if (pulses != '0) begin
        if (exp_q.size() == 0)
          chk("unexpected_pulse", 72'(pulses), 72'(0));
        else
          chk("event", 72'(pack_evt(cyc, pulses, int'(balance), int'(tries_left),
                                    int'(dispense_amt))), 72'(exp_q.pop_front()));
      end else if (exp_q.size() > 0) begin
        chk("missing_pulse", 72'(0), 72'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
  endtask

  task automatic insert_card();
    card_in = 1'b1; tick(); card_in = 1'b0;
  endtask

  task automatic send_pin(input logic [15:0] p, input logic c);
    pin_valid = 1'b1; pin = p; cancel = c; tick();
    pin_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic send_amt(input logic [15:0] a);
    amt_valid = 1'b1; amount = a; tick(); amt_valid = 1'b0;
  endtask

  task automatic send_ack();
    dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; card_in = 0; pin_valid = 0; amt_valid = 0; cancel = 0;
    dispense_ack = 0; pin = '0; amount = '0;
    tick(3); reset = 1'b0; tick(2);

    // happy path
    insert_card(); send_pin(16'h1234, 1'b0); send_amt(16'd100); tick(4); send_ack(); tick(2);

    // lockout, with a card held during the lock
    insert_card(); send_pin(16'h0001, 1'b0); send_pin(16'h0002, 1'b0); send_pin(16'h0003, 1'b0);
    card_in = 1'b1; tick(5); card_in = 1'b0; tick(8);

    // reset in the middle of a dispense
    do_reset(); insert_card(); send_pin(16'h1234, 1'b0); send_amt(16'd200); tick(2);
    do_reset(); tick(2);

    // amount rejects, then the full balance
    insert_card(); send_pin(16'h1234, 1'b0);
    send_amt(16'd0); send_amt(16'd600); send_amt(16'd500); tick(3); send_ack(); tick(2);

    // inactivity timeout, then a late strobe restarting the timer
    insert_card(); tick(20);
    insert_card(); tick(14); send_pin(16'h0bad, 1'b0); tick(20);

    // cancel priority over a correct PIN; cancel/strobes ignored in DISPENSE
    do_reset(); insert_card(); send_pin(16'h1234, 1'b1); tick(2);
    insert_card(); send_pin(16'h1234, 1'b0); send_amt(16'd50);
    cancel = 1'b1; pin_valid = 1'b1; amt_valid = 1'b1; amount = 16'd10; tick(3);
    cancel = 1'b0; pin_valid = 1'b0; amt_valid = 1'b0; send_ack(); tick(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      card_in      = ($urandom_range(0, 9) == 0);
      pin_valid    = ($urandom_range(0, 5) == 0);
      pin          = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h1234;
      amt_valid    = ($urandom_range(0, 4) == 0);
      amount       = 16'($urandom_range(0, 650));
      cancel       = ($urandom_range(0, 30) == 0);
      dispense_ack = ($urandom_range(0, 6) == 0);
      reset        = ($urandom_range(0, 400) == 0);
      tick();
    end
    card_in = 0; pin_valid = 0; amt_valid = 0; cancel = 0; dispense_ack = 0; reset = 0;
    tick(30);

    chk("queue_empty", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller. Sequences card insertion, PIN check with retry limit and lockout, withdrawal amount validation against a held account balance, and dispense handshake, with an inactivity timeout. Sits between the keypad/card front-end and the cash-dispenser interface. Generalises the four-state PIN/valid/amount controller.

## Interface
- PIN_W, 16, PIN width in bits
- PIN_VALUE, 16'h1234, stored PIN (PIN_W bits)
- AMT_W, 16, amount width
- BAL_W, 24, balance width (BAL_W >= AMT_W)
- INIT_BALANCE, 500, balance loaded at reset
- MAX_TRIES, 3, PIN attempts per session, 1..15
- TIMEOUT_CYC, 1000, inactivity limit in cycles, >= 2
- LOCK_CYC, 5000, lockout duration in cycles, >= 1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- card_in  in  1  card-present strobe; sampled only in IDLE
- pin_valid  in  1  pin qualifier, one-cycle strobe
- pin  in  PIN_W  entered PIN
- amt_valid  in  1  amount qualifier, one-cycle strobe
- amount  in  AMT_W  requested withdrawal
- cancel  in  1  abort session
- dispense_ack  in  1  dispenser completed payout
- state  out  3  IDLE=0, PIN_ENTRY=1, AMOUNT_ENTRY=2, DISPENSE=3, LOCKED=4
- pin_ok  out  1  pulse: PIN accepted
- pin_err  out  1  pulse: PIN rejected
- amt_err  out  1  pulse: amount zero or exceeds balance
- timeout  out  1  pulse: session expired
- done  out  1  pulse: withdrawal completed
- locked  out  1  high while in LOCKED
- dispense_req  out  1  high while in DISPENSE
- dispense_amt  out  AMT_W  latched approved amount
- balance  out  BAL_W  current balance
- tries_left  out  4  remaining PIN attempts

## Operation
- All outputs registered. Reset: state=IDLE, all pulses 0, locked=0, dispense_req=0, dispense_amt=0, balance=INIT_BALANCE, tries_left=MAX_TRIES. Reset mid-session aborts with no balance change.
- IDLE: card_in -> PIN_ENTRY; tries_left reloaded to MAX_TRIES; timer cleared. Other inputs ignored.
- PIN_ENTRY, priority cancel > pin_valid > timeout:
  - cancel -> IDLE, no pulse.
  - pin_valid, pin==PIN_VALUE -> AMOUNT_ENTRY, pin_ok.
  - pin_valid, mismatch -> pin_err, tries_left-1; if tries_left was 1 -> LOCKED (tries_left=0), else stay.
  - timer expiry -> IDLE, timeout.
- AMOUNT_ENTRY, priority cancel > amt_valid > timeout:
  - amount==0 or amount > balance (zero-extended compare) -> amt_err, stay.
  - otherwise latch dispense_amt=amount -> DISPENSE.
  - cancel / expiry as in PIN_ENTRY.
- DISPENSE: dispense_req=1; cancel, pin_valid, amt_valid ignored; no timeout. On dispense_ack: balance -= dispense_amt, done, -> IDLE. Balance never underflows (checked at approval).
- LOCKED: locked=1; all inputs except reset ignored; after LOCK_CYC cycles -> IDLE, tries_left=MAX_TRIES.
- Inactivity timer: cleared on entry to PIN_ENTRY/AMOUNT_ENTRY and on any pin_valid/amt_valid in those states; increments otherwise. Expires on the cycle it equals TIMEOUT_CYC-1 with no cancel/strobe.
- dispense_amt holds value until next approval.

## Timing
- Every transition occurs on the edge sampling its cause; new state and associated pulse are visible together in the following cycle, pulse exactly one cycle wide.
- card_in to PIN_ENTRY: 1 cycle. dispense_ack to balance update + done + IDLE: 1 cycle.
- Timeout: strobe-free PIN_ENTRY/AMOUNT_ENTRY exits TIMEOUT_CYC cycles after entry or after last strobe.
- LOCKED lasts exactly LOCK_CYC cycles (state==4 for LOCK_CYC consecutive cycles).
- dispense_req asserts the cycle state becomes DISPENSE, deasserts the cycle state returns to IDLE.
- Strobes in a state that does not sample them are dropped, not queued.

## Test plan
Params PIN_VALUE=16'h1234, INIT_BALANCE=500, MAX_TRIES=3, TIMEOUT_CYC=16, LOCK_CYC=8.
- Happy path: card_in, pin=1234, amount=100, ack after 5 cycles -> pin_ok, dispense_req 5 cycles, dispense_amt=100, done, balance=400, state=0.
- Lockout: three wrong pins -> pin_err x3, tries_left 2,1,0, state=4 for exactly 8 cycles, then IDLE with tries_left=3; card_in during LOCKED ignored.
- Amount rejects: amount=0 then amount=600 with balance 500 -> two amt_err, stay state 2; amount=500 accepted, after ack balance=0.
- Timeout: card_in then 16 idle cycles -> timeout pulse, state=0; pin_valid at cycle 15 instead restarts timer.
- Cancel priority: cancel and correct pin_valid same cycle in PIN_ENTRY -> IDLE, no pin_ok; cancel in DISPENSE ignored.
- Reset mid-DISPENSE before ack -> state=0, dispense_req=0, balance=500.
